// File: rtl/frame_time_sync.sv
// frame_time_sync
//   Keeps a local time of day that is resynchronised from frames delivered by
//   an SPI receiver. The clock-hand positions for the VGA clock face are
//   re-latched once per video frame, on the vsync falling edge, so they never
//   change while a frame is being drawn.
//
// Ports
//   vgaclk       in   pixel clock, the only clock
//   reset        in   synchronous, active-high reset
//   frame_valid  in   one-cycle strobe: hour_in/minute_in/second_in are valid
//   hour_in      in   [4:0] hour 0..23
//   minute_in    in   [5:0] minute 0..59
//   second_in    in   [5:0] second 0..59
//   vsync        in   active-low vertical sync
//   sec_out      out  [5:0] second-hand tick position 0..59
//   min_out      out  [5:0] minute-hand tick position 0..59
//   hr_tick      out  [5:0] hour-hand tick position 0..59
//   time_ok      out  set once the first received frame has been displayed
//   bad_frame    out  sticky: an out-of-range frame was received
//   frame_done   out  one-cycle strobe when the hand outputs update
module frame_time_sync #(
  parameter int TICK_DIV = 25175000
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       frame_valid,
  input  logic [4:0] hour_in,
  input  logic [5:0] minute_in,
  input  logic [5:0] second_in,
  input  logic       vsync,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [5:0] hr_tick,
  output logic       time_ok,
  output logic       bad_frame,
  output logic       frame_done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SNAP, DIV, COMMIT} state_t;

  state_t     state, state_nxt;

  logic       vsync_q;
  logic       vs_fall;
  logic       frame_ok;
  logic       tick;

  logic [4:0] pend_h, wrk_h, snap_h;
  logic [5:0] pend_m, wrk_m, snap_m;
  logic [5:0] pend_s, wrk_s, snap_s;
  logic       pend_valid;
  logic       snap_pend;

  logic [PW-1:0] presc;
  logic [5:0]    rem;
  logic [2:0]    q;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  // Hour hand base position: (h mod 12) * 5; h is always below 24.
  function automatic logic [5:0] hour_base(input logic [4:0] h);
    logic [4:0] h12;
    h12 = (h >= 5'd12) ? h - 5'd12 : h;
    return 6'(h12) * 6'd5;
  endfunction

  assign vs_fall  = vsync_q & ~vsync;
  assign frame_ok = (hour_in < 5'd24) && (minute_in < 6'd60) && (second_in < 6'd60);
  assign tick     = time_ok && (presc == PRESC_MAX);

  always_ff @(posedge vgaclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_fall) state_nxt = SNAP;
      SNAP:    state_nxt = DIV;
      DIV:     if (rem < 6'd12) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Later assignments in this block intentionally override earlier ones:
  // a pending load in SNAP beats a tick, and a new valid frame in SNAP
  // re-sets pend_valid after SNAP cleared it.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      vsync_q    <= 1'b1;
      sec_out    <= '0;
      min_out    <= '0;
      hr_tick    <= '0;
      time_ok    <= 1'b0;
      bad_frame  <= 1'b0;
      frame_done <= 1'b0;
      pend_valid <= 1'b0;
      pend_h     <= '0;
      pend_m     <= '0;
      pend_s     <= '0;
      wrk_h      <= '0;
      wrk_m      <= '0;
      wrk_s      <= '0;
      snap_h     <= '0;
      snap_m     <= '0;
      snap_s     <= '0;
      snap_pend  <= 1'b0;
      presc      <= '0;
      rem        <= '0;
      q          <= '0;
    end else begin
      vsync_q    <= vsync;
      frame_done <= 1'b0;

      // one-second prescaler and free-running working time
      if (time_ok) presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        wrk_s <= inc60(wrk_s);
        if (wrk_s == 6'd59) begin
          wrk_m <= inc60(wrk_m);
          if (wrk_m == 6'd59) wrk_h <= inc24(wrk_h);
        end
      end

      case (state)
        SNAP: begin
          if (pend_valid) begin
            wrk_h      <= pend_h;
            wrk_m      <= pend_m;
            wrk_s      <= pend_s;
            snap_h     <= pend_h;
            snap_m     <= pend_m;
            snap_s     <= pend_s;
            rem        <= pend_m;
            presc      <= '0;
            pend_valid <= 1'b0;
            snap_pend  <= 1'b1;
          end else begin
            snap_h     <= wrk_h;
            snap_m     <= wrk_m;
            snap_s     <= wrk_s;
            rem        <= wrk_m;
            snap_pend  <= 1'b0;
          end
          q <= '0;
        end
        // minute / 12 by repeated subtraction gives the hour-hand sub-step
        DIV: begin
          if (rem >= 6'd12) begin
            rem <= rem - 6'd12;
            q   <= q + 3'd1;
          end
        end
        COMMIT: begin
          sec_out    <= snap_s;
          min_out    <= snap_m;
          hr_tick    <= hour_base(snap_h) + 6'(q);
          frame_done <= 1'b1;
          if (snap_pend) time_ok <= 1'b1;
        end
        default: ;
      endcase

      if (frame_valid) begin
        if (frame_ok) begin
          pend_h     <= hour_in;
          pend_m     <= minute_in;
          pend_s     <= second_in;
          pend_valid <= 1'b1;
        end else begin
          bad_frame  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_time_sync.sv
module tb_frame_time_sync;

  logic       vgaclk = 1'b0;
  logic       reset;
  logic       frame_valid;
  logic [4:0] hour_in;
  logic [5:0] minute_in;
  logic [5:0] second_in;
  logic       vsync;
  logic [5:0] sec_out, min_out, hr_tick;
  logic       time_ok, bad_frame, frame_done;

  int errors = 0;
  int checks = 0;

  frame_time_sync #(.TICK_DIV(10)) dut (
    .vgaclk     (vgaclk),
    .reset      (reset),
    .frame_valid(frame_valid),
    .hour_in    (hour_in),
    .minute_in  (minute_in),
    .second_in  (second_in),
    .vsync      (vsync),
    .sec_out    (sec_out),
    .min_out    (min_out),
    .hr_tick    (hr_tick),
    .time_ok    (time_ok),
    .bad_frame  (bad_frame),
    .frame_done (frame_done)
  );

  always #5 vgaclk = ~vgaclk;

  typedef struct {
    int h, m, s;
    int e_sec, e_min, e_hr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input int h, input int m, input int s);
    @(negedge vgaclk);
    hour_in     = 5'(h);
    minute_in   = 6'(m);
    second_in   = 6'(s);
    frame_valid = 1'b1;
    @(negedge vgaclk);
    frame_valid = 1'b0;
  endtask

  // Waits for frame_done; n = negedges waited, 0 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge vgaclk);
      if (frame_done) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got no pulse, expected one within 20 cycles");
    end
  endtask

  // Raise vsync again and confirm frame_done was a single-cycle pulse.
  task automatic finish_frame(input string name);
    vsync = 1'b1;
    @(negedge vgaclk);
    check({name, "_done_pulse"}, int'(frame_done), 0);
    @(negedge vgaclk);
  endtask

  task automatic check_outs(input string name, input int es, input int em, input int eh, input int eok);
    check({name, "_sec"},     int'(sec_out), es);
    check({name, "_min"},     int'(min_out), em);
    check({name, "_hr"},      int'(hr_tick), eh);
    check({name, "_time_ok"}, int'(time_ok), eok);
  endtask

  initial begin
    int n;
    int seen;

    vecs[0] = '{h:10, m:7,  s:30, e_sec:30, e_min:7,  e_hr:50};
    vecs[1] = '{h:3,  m:48, s:0,  e_sec:0,  e_min:48, e_hr:19};
    vecs[2] = '{h:12, m:11, s:0,  e_sec:0,  e_min:11, e_hr:0};
    vecs[3] = '{h:15, m:59, s:0,  e_sec:0,  e_min:59, e_hr:19};
    vecs[4] = '{h:0,  m:0,  s:0,  e_sec:0,  e_min:0,  e_hr:0};
    vecs[5] = '{h:11, m:36, s:5,  e_sec:5,  e_min:36, e_hr:58};
    vecs[6] = '{h:6,  m:12, s:0,  e_sec:0,  e_min:12, e_hr:31};
    vecs[7] = '{h:23, m:59, s:59, e_sec:59, e_min:59, e_hr:59};

    reset       = 1'b1;
    vsync       = 1'b1;
    frame_valid = 1'b0;
    hour_in     = '0;
    minute_in   = '0;
    second_in   = '0;
    repeat (3) @(negedge vgaclk);
    reset = 1'b0;

    check_outs("reset", 0, 0, 0, 0);
    check("reset_bad_frame",  int'(bad_frame),  0);
    check("reset_frame_done", int'(frame_done), 0);

    // Out-of-range frame: flagged, not loaded; commit still shows zeros.
    send_frame(24, 30, 0);
    check("bad_frame_set", int'(bad_frame), 1);
    @(negedge vgaclk);
    vsync = 1'b0;
    wait_done(n);
    check_outs("bad", 0, 0, 0, 0);
    check("bad_latency", n, 4);
    finish_frame("bad");
    check("bad_frame_sticky", int'(bad_frame), 1);

    // Table of valid frames, each committed from pending.
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].h, vecs[i].m, vecs[i].s);
      @(negedge vgaclk);
      vsync = 1'b0;
      wait_done(n);
      check_outs($sformatf("vec%0d", i), vecs[i].e_sec, vecs[i].e_min, vecs[i].e_hr, 1);
      check($sformatf("vec%0d_latency", i), n, vecs[i].m / 12 + 4);
      finish_frame($sformatf("vec%0d", i));
    end

    // 23:59:59 was just committed; after one tick the next frame rolls over.
    repeat (6) @(negedge vgaclk);
    vsync = 1'b0;
    wait_done(n);
    check_outs("rollover", 0, 0, 0, 1);
    finish_frame("rollover");

    // New frame arriving in the SNAP cycle: old pending shown now, new next.
    send_frame(8, 0, 0);
    @(negedge vgaclk);
    vsync = 1'b0;
    @(negedge vgaclk);
    hour_in     = 5'd9;
    minute_in   = 6'd0;
    second_in   = 6'd0;
    frame_valid = 1'b1;
    @(negedge vgaclk);
    frame_valid = 1'b0;
    wait_done(n);
    check_outs("snap_race_first", 0, 0, 40, 1);
    finish_frame("snap_race_first");
    vsync = 1'b0;
    wait_done(n);
    check_outs("snap_race_second", 0, 0, 45, 1);
    finish_frame("snap_race_second");

    // Reset in the middle of DIV.
    send_frame(3, 48, 0);
    @(negedge vgaclk);
    vsync = 1'b0;
    @(negedge vgaclk);
    @(negedge vgaclk);
    reset = 1'b1;
    vsync = 1'b1;
    @(negedge vgaclk);
    reset = 1'b0;
    check_outs("mid_div_reset", 0, 0, 0, 0);
    check("mid_div_reset_bad_frame",  int'(bad_frame),  0);
    check("mid_div_reset_frame_done", int'(frame_done), 0);
    seen = 0;
    repeat (8) begin
      @(negedge vgaclk);
      if (frame_done) seen++;
    end
    check("mid_div_reset_no_done", seen, 0);

    // First edge after reset is detected; pending was cleared, so zeros.
    vsync = 1'b0;
    wait_done(n);
    check_outs("post_reset", 0, 0, 0, 0);
    check("post_reset_latency", n, 4);
    finish_frame("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_time_sync.md
FRAME_TIME_SYNC -- requirements
Module: frame_time_sync

Interface
REQ-001 Parameter TICK_DIV, default 25175000, gives the number of vgaclk cycles per local one-second tick; legal range 2..2^25.
REQ-002 vgaclk  in  1  the only clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 frame_valid  in  1  one-cycle pulse: a new time frame from the SPI receiver is present on hour_in/minute_in/second_in.
REQ-005 hour_in  in  5  hour 0..23; minute_in  in  6  minute 0..59; second_in  in  6  second 0..59.
REQ-006 vsync  in  1  active-low vertical sync from the VGA timing controller.
REQ-007 sec_out  out  6  second-hand tick position 0..59.
REQ-008 min_out  out  6  minute-hand tick position 0..59.
REQ-009 hr_tick  out  6  hour-hand tick position 0..59.
REQ-010 time_ok  out  1  1 once the first valid frame has been committed.
REQ-011 bad_frame  out  1  sticky flag; a range-invalid frame was received.
REQ-012 frame_done  out  1  one-cycle pulse when the outputs update.

Function
REQ-013 The block shall validate each frame_valid pulse: hour_in<24, minute_in<60 and second_in<60.
REQ-014 On a valid frame it shall write the frame into a pending register and set pend_valid; a later valid frame overwrites it (latest wins).
REQ-015 On an invalid frame it shall set bad_frame and leave the pending register and pend_valid unchanged.
REQ-016 The working time (h, m, s) shall advance only while time_ok=1; a prescaler counts 0..TICK_DIV-1, and each wrap is a tick.
REQ-017 Tick arithmetic: s+1; s=59 wraps to 0 and carries to m; m=59 wraps to 0 and carries to h; h=23 wraps to 0.
REQ-018 The sequencer FSM shall have the states IDLE, SNAP, DIV and COMMIT.
REQ-019 IDLE->SNAP on a vsync falling edge (registered vsync=1, current vsync=0); all other vsync activity is ignored outside IDLE.
REQ-020 SNAP (1 cycle) shall act as follows:
- pend_valid=1: copy pending to working time and snapshot, clear prescaler, clear pend_valid.
- pend_valid=0: copy working time to snapshot.
- Next state DIV with rem=snapshot minute, q=0.
REQ-021 DIV: while rem>=12, rem-=12 and q+=1, one step per cycle; when rem<12, go to COMMIT. DIV lasts q+1 cycles, at most 5.
REQ-022 COMMIT (1 cycle) shall do all of the following, then return to IDLE:
- sec_out=snap s; min_out=snap m.
- hr_tick=(snap h mod 12)*5+q.
- frame_done=1.
- time_ok=1 if the snapshot came from pending.
REQ-023 Latency from the vsync falling edge (cycle 0) to updated outputs: cycle 1 SNAP, DIV cycles, COMMIT; outputs are visible after at most 8 cycles.
REQ-024 sec_out, min_out and hr_tick shall change only in COMMIT; they stay stable for the whole visible frame.
REQ-025 A tick in the same cycle as a SNAP load from pending is discarded (load wins); a tick without a pending load applies normally.
REQ-026 A valid frame_valid in the SNAP cycle: SNAP uses the old pending value, and the new value is stored with pend_valid=1 (set wins over clear).
REQ-027 While time_ok=0 and pend_valid=0, COMMIT shall output zeros.

Reset
REQ-028 While reset=1 the block shall hold the following, independent of state (including mid-DIV):
- state=IDLE.
- sec_out=min_out=hr_tick=0.
- time_ok=0, bad_frame=0, frame_done=0.
- pend_valid=0, prescaler=0, working time=0.
- registered vsync=1.
REQ-029 The first vsync falling edge after reset release shall be detected normally.

Verification (TICK_DIV=10)
REQ-030 Reset; frame 10:07:30; vsync 1->0 -> within 8 cycles sec_out=30, min_out=7, hr_tick=50, time_ok=1, one frame_done pulse.
REQ-031 Frame 23:59:59 committed, 10 cycles elapse, next vsync edge -> sec_out=0, min_out=0, hr_tick=0.
REQ-032 Frames 3:48 -> hr_tick=19 (DIV 5 cycles); frame 12:11 -> hr_tick=0; frame 15:59 -> hr_tick=19.
REQ-033 Frame hour_in=24 -> bad_frame=1; outputs and time_ok unchanged at the next COMMIT.
REQ-034 frame_valid 9:00:00 in the SNAP cycle while pending holds 8:00:00 -> this frame shows 8:00:00 and the next frame shows 9:00:00.
REQ-035 reset pulsed during DIV -> next cycle all outputs 0, state IDLE, no frame_done.
